drop_sequencer: RTL and testbench

DROP_SEQUENCER -- requirements
Module: drop_sequencer

---
 rtl/drop_sequencer.sv | 156 +++++++++++++++
 tb/tb_drop_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/drop_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : drop_sequencer
// Purpose  : Arms on a run of stable height samples, then gates a fixed-length
//            release pulse on operator request when the height is low enough.
// Revision : 1.0
// ============================================================================
module drop_sequencer #(
    parameter int STABLE_CNT  = 4,
    parameter int TOL         = 2,
    parameter int DROP_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] height,
    input  logic       height_valid,
    input  logic [7:0] drop_limit,
    input  logic       drop_req,
    output logic       drop_en,
    output logic       armed,
    output logic       busy,
    output logic [7:0] stable_height,
    output logic       fault
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_ARMED = 2'd2,
        ST_DROP  = 2'd3
    } state_t;

    localparam logic [3:0] C_STABLE = 4'(STABLE_CNT);
    localparam logic [8:0] C_TOL    = 9'(TOL);
    localparam logic [7:0] C_DROP   = 8'(DROP_CYCLES);

    state_t     state_q, state_d;
    logic [7:0] ref_q, ref_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] timer_q, timer_d;
    logic [7:0] stable_height_q, stable_height_d;
    logic       drop_en_q, drop_en_d;
    logic       armed_q, armed_d;
    logic       busy_q, busy_d;
    logic       fault_q, fault_d;

    logic       w_sample;
    logic       w_zero;
    logic [8:0] w_h9;
    logic [8:0] w_r9;
    logic [8:0] w_diff;
    logic       w_in_tol;
    logic [3:0] w_cnt_inc;

    // Absolute difference on 9 bits so a small ref against a large height never wraps.
    assign w_sample  = height_valid && (height != 8'd0);
    assign w_zero    = height_valid && (height == 8'd0);
    assign w_h9      = {1'b0, height};
    assign w_r9      = {1'b0, ref_q};
    assign w_diff    = (w_h9 >= w_r9) ? (w_h9 - w_r9) : (w_r9 - w_h9);
    assign w_in_tol  = w_sample && (w_diff <= C_TOL);
    assign w_cnt_inc = cnt_q + 4'd1;

    always_comb begin
        state_d         = state_q;
        ref_d           = ref_q;
        cnt_d           = cnt_q;
        timer_d         = timer_q;
        stable_height_d = stable_height_q;
        fault_d         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_sample) begin
                    ref_d   = height;
                    cnt_d   = 4'd1;
                    state_d = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (w_zero) begin
                    state_d = ST_IDLE;
                end else if (w_in_tol) begin
                    cnt_d = w_cnt_inc;
                    if (w_cnt_inc == C_STABLE) begin
                        state_d         = ST_ARMED;
                        stable_height_d = ref_q;
                    end
                end else if (w_sample) begin
                    ref_d = height;
                    cnt_d = 4'd1;
                end
            end
            ST_ARMED: begin
                // A disturbed height outranks any request in the same cycle.
                if (w_zero) begin
                    state_d = ST_IDLE;
                end else if (w_sample && !w_in_tol) begin
                    ref_d   = height;
                    cnt_d   = 4'd1;
                    state_d = ST_TRACK;
                end else if (drop_req) begin
                    if (stable_height_q <= drop_limit) begin
                        timer_d = C_DROP;
                        state_d = ST_DROP;
                    end else begin
                        fault_d = 1'b1;
                    end
                end
            end
            ST_DROP: begin
                timer_d = timer_q - 8'd1;
                if (timer_q <= 8'd1) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        drop_en_d = (state_d == ST_DROP);
        armed_d   = (state_d == ST_ARMED);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            ref_q           <= 8'd0;
            cnt_q           <= 4'd0;
            timer_q         <= 8'd0;
            stable_height_q <= 8'd0;
            drop_en_q       <= 1'b0;
            armed_q         <= 1'b0;
            busy_q          <= 1'b0;
            fault_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            ref_q           <= ref_d;
            cnt_q           <= cnt_d;
            timer_q         <= timer_d;
            stable_height_q <= stable_height_d;
            drop_en_q       <= drop_en_d;
            armed_q         <= armed_d;
            busy_q          <= busy_d;
            fault_q         <= fault_d;
        end
    end

    assign drop_en       = drop_en_q;
    assign armed         = armed_q;
    assign busy          = busy_q;
    assign stable_height = stable_height_q;
    assign fault         = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_drop_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_drop_sequencer
// Purpose  : Directed scenario bench for drop_sequencer with hand-derived values.
// Revision : 1.0
// ============================================================================
module tb_drop_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] height;
    logic       height_valid;
    logic [7:0] drop_limit;
    logic       drop_req;
    logic       drop_en;
    logic       armed;
    logic       busy;
    logic [7:0] stable_height;
    logic       fault;

    int n_cmp  = 0;
    int n_fail = 0;

    drop_sequencer #(.STABLE_CNT(4), .TOL(2), .DROP_CYCLES(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .height       (height),
        .height_valid (height_valid),
        .drop_limit   (drop_limit),
        .drop_req     (drop_req),
        .drop_en      (drop_en),
        .armed        (armed),
        .busy         (busy),
        .stable_height(stable_height),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [7:0] h);
        height_valid = 1'b1;
        height       = h;
        tick();
        height_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; height_valid = 1'b1; height = 8'd50; drop_req = 1'b1; drop_limit = 8'd255;
        tick(); tick();
        n_cmp++; if (drop_en !== 1'b0) begin n_fail++; $display("FAIL reset_drop_en got=%0b exp=0", drop_en); end
        n_cmp++; if (armed !== 1'b0) begin n_fail++; $display("FAIL reset_armed got=%0b exp=0", armed); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        n_cmp++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got=%0b exp=0", fault); end
        n_cmp++; if (stable_height !== 8'd0) begin n_fail++; $display("FAIL reset_stable got=%0d exp=0", stable_height); end
        rst = 1'b0; height_valid = 1'b0; height = 8'd0; drop_req = 1'b0;
        tick();
    endtask

    task automatic test_arm();
        sample(8'd100); sample(8'd101); sample(8'd99);
        n_cmp++; if (armed !== 1'b0) begin n_fail++; $display("FAIL arm_early got=%0b exp=0", armed); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL arm_track_busy got=%0b exp=1", busy); end
        sample(8'd100);
        n_cmp++; if (armed !== 1'b1) begin n_fail++; $display("FAIL arm_armed got=%0b exp=1", armed); end
        n_cmp++; if (stable_height !== 8'd100) begin n_fail++; $display("FAIL arm_stable got=%0d exp=100", stable_height); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL arm_busy got=%0b exp=1", busy); end
    endtask

    task automatic test_drop();
        drop_limit = 8'd120; drop_req = 1'b1;
        tick();
        drop_req = 1'b0;
        n_cmp++; if (drop_en !== 1'b1) begin n_fail++; $display("FAIL drop_start got=%0b exp=1", drop_en); end
        n_cmp++; if (armed !== 1'b0) begin n_fail++; $display("FAIL drop_armed got=%0b exp=0", armed); end
        for (int i = 2; i <= 8; i++) begin
            tick();
            n_cmp++; if (drop_en !== 1'b1) begin n_fail++; $display("FAIL drop_hold cyc=%0d got=%0b exp=1", i, drop_en); end
        end
        tick();
        n_cmp++; if (drop_en !== 1'b0) begin n_fail++; $display("FAIL drop_end got=%0b exp=0", drop_en); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_end_busy got=%0b exp=0", busy); end
        n_cmp++; if (armed !== 1'b0) begin n_fail++; $display("FAIL drop_end_armed got=%0b exp=0", armed); end
        n_cmp++; if (stable_height !== 8'd100) begin n_fail++; $display("FAIL drop_end_stable got=%0d exp=100", stable_height); end
    endtask

    task automatic test_fault();
        sample(8'd100); sample(8'd100); sample(8'd100); sample(8'd100);
        drop_limit = 8'd90; drop_req = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_cmp++; if (fault !== 1'b1) begin n_fail++; $display("FAIL fault_pulse cyc=%0d got=%0b exp=1", i, fault); end
            n_cmp++; if (drop_en !== 1'b0) begin n_fail++; $display("FAIL fault_drop_en cyc=%0d got=%0b exp=0", i, drop_en); end
            n_cmp++; if (armed !== 1'b1) begin n_fail++; $display("FAIL fault_armed cyc=%0d got=%0b exp=1", i, armed); end
        end
        drop_req = 1'b0;
        tick();
        n_cmp++; if (fault !== 1'b0) begin n_fail++; $display("FAIL fault_clear got=%0b exp=0", fault); end
    endtask

    task automatic test_priority();
        drop_limit = 8'd120; drop_req = 1'b1; height_valid = 1'b1; height = 8'd110;
        tick();
        drop_req = 1'b0; height_valid = 1'b0;
        n_cmp++; if (drop_en !== 1'b0) begin n_fail++; $display("FAIL prio_drop_en got=%0b exp=0", drop_en); end
        n_cmp++; if (armed !== 1'b0) begin n_fail++; $display("FAIL prio_armed got=%0b exp=0", armed); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL prio_busy got=%0b exp=1", busy); end
        sample(8'd110); sample(8'd110); sample(8'd110); sample(8'd110);
        n_cmp++; if (armed !== 1'b1) begin n_fail++; $display("FAIL prio_rearm got=%0b exp=1", armed); end
        n_cmp++; if (stable_height !== 8'd110) begin n_fail++; $display("FAIL prio_stable got=%0d exp=110", stable_height); end
    endtask

    task automatic test_restart();
        rst = 1'b1; tick(); rst = 1'b0;
        sample(8'd100); sample(8'd100); sample(8'd200); sample(8'd200); sample(8'd200);
        n_cmp++; if (armed !== 1'b0) begin n_fail++; $display("FAIL restart_early got=%0b exp=0", armed); end
        sample(8'd200);
        n_cmp++; if (armed !== 1'b1) begin n_fail++; $display("FAIL restart_armed got=%0b exp=1", armed); end
        n_cmp++; if (stable_height !== 8'd200) begin n_fail++; $display("FAIL restart_stable got=%0d exp=200", stable_height); end
        sample(8'd0);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL armed_zero_busy got=%0b exp=0", busy); end
        sample(8'd50);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL track_busy got=%0b exp=1", busy); end
        sample(8'd0);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL track_zero_busy got=%0b exp=0", busy); end
        n_cmp++; if (stable_height !== 8'd200) begin n_fail++; $display("FAIL idle_stable_hold got=%0d exp=200", stable_height); end
    endtask

    task automatic test_tol_boundary();
        sample(8'd100); sample(8'd102); sample(8'd98); sample(8'd103);
        n_cmp++; if (armed !== 1'b0) begin n_fail++; $display("FAIL tol_out got=%0b exp=0", armed); end
        sample(8'd101); sample(8'd105);
        n_cmp++; if (armed !== 1'b0) begin n_fail++; $display("FAIL tol_early got=%0b exp=0", armed); end
        sample(8'd103);
        n_cmp++; if (armed !== 1'b1) begin n_fail++; $display("FAIL tol_armed got=%0b exp=1", armed); end
        n_cmp++; if (stable_height !== 8'd103) begin n_fail++; $display("FAIL tol_stable got=%0d exp=103", stable_height); end
        drop_limit = 8'd102; drop_req = 1'b1;
        tick();
        n_cmp++; if (fault !== 1'b1) begin n_fail++; $display("FAIL limit_above_fault got=%0b exp=1", fault); end
        drop_limit = 8'd103;
        tick();
        drop_req = 1'b0;
        n_cmp++; if (drop_en !== 1'b1) begin n_fail++; $display("FAIL limit_equal_drop got=%0b exp=1", drop_en); end
        n_cmp++; if (fault !== 1'b0) begin n_fail++; $display("FAIL limit_equal_fault got=%0b exp=0", fault); end
        for (int i = 0; i < 8; i++) tick();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL limit_drop_done got=%0b exp=0", busy); end
        sample(8'd1); sample(8'd1); sample(8'd1); sample(8'd255);
        n_cmp++; if (armed !== 1'b0) begin n_fail++; $display("FAIL nowrap_armed got=%0b exp=0", armed); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL nowrap_busy got=%0b exp=1", busy); end
        sample(8'd0);
    endtask

    task automatic test_gap_reset();
        sample(8'd60);
        tick(); tick(); tick();
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL gap_busy got=%0b exp=1", busy); end
        sample(8'd61); sample(8'd59);
        n_cmp++; if (armed !== 1'b0) begin n_fail++; $display("FAIL gap_early got=%0b exp=0", armed); end
        sample(8'd60);
        n_cmp++; if (armed !== 1'b1) begin n_fail++; $display("FAIL gap_armed got=%0b exp=1", armed); end
        n_cmp++; if (stable_height !== 8'd60) begin n_fail++; $display("FAIL gap_stable got=%0d exp=60", stable_height); end
        drop_limit = 8'd255; drop_req = 1'b1;
        tick();
        drop_req = 1'b0;
        tick(); tick();
        n_cmp++; if (drop_en !== 1'b1) begin n_fail++; $display("FAIL mid_drop got=%0b exp=1", drop_en); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (drop_en !== 1'b0) begin n_fail++; $display("FAIL rst_drop_en got=%0b exp=0", drop_en); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_drop_busy got=%0b exp=0", busy); end
        n_cmp++; if (stable_height !== 8'd0) begin n_fail++; $display("FAIL rst_drop_stable got=%0d exp=0", stable_height); end
    endtask

    initial begin
        rst = 1'b1; height = 8'd0; height_valid = 1'b0; drop_limit = 8'd0; drop_req = 1'b0;
        test_reset();
        test_arm();
        test_drop();
        test_fault();
        test_priority();
        test_restart();
        test_tol_boundary();
        test_gap_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
